axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
- AXI3 responder backing a word-organised on-chip RAM. It is the slave-side counterpart of the cache-to-AXI bridge and serves as the simulation and bring-up target for the CPU memory path.
- Independent read and write channel FSMs, one outstanding transaction per direction.
- Supports FIXED/INCR bursts up to 16 beats with byte strobes.

Parameters:
- DEPTH, 4096, RAM size in 32-bit words (power of two).
- BASE_ADDR, 32'h1fc00000, byte address of word 0.
- ID_W, 4, AXI ID width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  in  4/32/4/3/2/2/4/3  read address channel (lock/cache/prot ignored)
- arvalid in 1; arready out 1
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel
- rready in 1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  in  4/32/4/3/2/2/4/3  write address channel (lock/cache/prot ignored)
- awvalid in 1; awready out 1
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data channel (wid ignored)
- wready out 1
- bid/bresp/bvalid  out  4/2/1  write response channel
- bready in 1

Behaviour:
- Reset (synchronous, active-high, on clk edge):
  - Both FSMs go to IDLE.
  - arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rresp=bresp=0, rid=bid=0, rdata=0.
  - RAM contents are preserved.
  - Reset mid-burst abandons the burst immediately; partial writes already committed remain.
- Address map:
  - Word index = (addr - BASE_ADDR) >> 2.
  - Out of range when the offset is >= DEPTH*4.
  - Out-of-range beats return rdata=0 with SLVERR (2'b10) and write nothing.
- Burst address update after each beat:
  - FIXED (00): unchanged.
  - INCR (01): addr += 1 << size.
  - WRAP (10) and reserved (11): handled as INCR; every beat flagged SLVERR.
- Data width rules:
  - rdata is always the full aligned word, regardless of size.
  - Writes use wstrb only.
  - size > 3'b010 returns SLVERR.
- Read FSM (R_IDLE, R_DATA):
  - R_IDLE: arready=1. On arvalid, latch id/addr/len/size/burst, set beat counter to 0, go to R_DATA.
  - The RAM read is registered, so the first rvalid appears the cycle after AR acceptance.
  - R_DATA: rvalid=1 and arready=0. rdata/rresp/rlast hold while rready=0.
  - rlast=1 when beat count == len.
  - On rvalid&&rready: if last beat, go to R_IDLE (arready=1 next cycle); otherwise advance the address and present the next beat the following cycle.
  - Back-to-back bursts therefore have a minimum 1-cycle gap.
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: awready=1, wready=0. On awvalid, latch id/addr/len/size/burst, clear the error flag, go to W_DATA.
  - W_DATA: wready=1. Each wvalid beat writes the RAM bytes enabled by wstrb in that cycle, then the address advances.
  - A wlast that disagrees with (count==len) sets the error flag.
  - The burst ends on the beat where count==len, regardless of wlast.
  - W_RESP: bvalid=1 and bid=latched id. bresp=SLVERR if any beat was out of range, bad size/burst, or wlast mismatch; OKAY otherwise. On bready, go to W_IDLE.
- Write data presented before AW acceptance is not accepted (wready=0 until W_DATA).
- Same-cycle read and write to the same word: the read returns old data (read-first).
- Read-after-write ordering across channels is not enforced.
- Master contract: the master keeps rready/bready high, so a zero-wait single-beat read completes in 2 cycles and a zero-wait single-beat write in 3.

Optional Feature:
- Macro AXI_SLAVE_STALL_EN.
- Defined:
  - A 16-bit LFSR (seed 16'hACE1 at reset, advances every cycle) gates the channels.
  - arready and awready are forced low when lfsr[0]=1.
  - wready is forced low when lfsr[1]=1.
  - rvalid and bvalid assertion is delayed while lfsr[2]=1. Once asserted they stay high until the handshake.
  - This stresses master backpressure handling.
- Undefined: no stalls; timing exactly as in Behaviour.

Decomposition:
- Shared package axi_pkg:
  - AXI_BURST_FIXED/INCR/WRAP
  - AXI_RESP_OKAY/SLVERR
  - FSM state typedefs for the read and write channels
  - helper function for the next burst address given addr/size/burst
- Sub-module axi_sram_mem: DEPTH x 32 RAM with one registered read port and one byte-strobed write port, read-first.
- The channel FSMs live in the top module.

Test Plan:
- Reset then single read at 0x1fc00000, mem[0]=32'h12345678, rready=1 -> rvalid exactly 1 cycle after AR handshake, rdata=32'h12345678, rresp=0, rlast=1, rid=arid.
- Write 0x1fc00010 wdata=32'hAABBCCDD wstrb=4'b0101, prior word 0 -> subsequent read returns 32'h00BB00DD, bresp=0, bid=awid.
- INCR read, arlen=3, size=2, at 0x1fc00020, rready toggled 1/0 -> 4 beats from consecutive words, data stable while stalled, rlast only on 4th beat.
- Write burst awlen=1 with wlast on first beat -> 2 beats written, bresp=2'b10; read at BASE_ADDR+DEPTH*4 -> rdata=0, rresp=2'b10.
- Simultaneous AR and AW to the same word, old=32'h1, new=32'h2 -> read returns 32'h1, later read returns 32'h2.
- Reset asserted mid 8-beat read at beat 3 -> next cycle rvalid=0, arready=1; new read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, channel FSM states and burst address helper
package axi_pkg;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  // WRAP and the reserved encoding step like INCR; only FIXED holds the address
  function automatic logic [31:0] axi_next_addr(input logic [31:0] addr,
                                                input logic [2:0]  size,
                                                input logic [1:0]  burst);
    if (burst == AXI_BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// rtl/axi_sram_mem.sv - DEPTH x 32 RAM, registered read port, byte-strobed write port, read-first
module axi_sram_mem #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [31:0]              rd_data,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [3:0]               wr_strb,
  input  logic [31:0]              wr_data
);

  logic [31:0] mem [DEPTH];

  // Read register and byte writes share one edge, so a same-word read sees the old data
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave over word RAM; AXI_SLAVE_STALL_EN enables LFSR stall injection
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h1fc00000,
  parameter int          ID_W      = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [3:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic [1:0]      arlock,
  input  logic [3:0]      arcache,
  input  logic [2:0]      arprot,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic [ID_W-1:0] awid,
  input  logic [31:0]     awaddr,
  input  logic [3:0]      awlen,
  input  logic [2:0]      awsize,
  input  logic [1:0]      awburst,
  input  logic [1:0]      awlock,
  input  logic [3:0]      awcache,
  input  logic [2:0]      awprot,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ID_W-1:0] wid,
  input  logic [31:0]     wdata,
  input  logic [3:0]      wstrb,
  input  logic            wlast,
  input  logic            wvalid,
  output logic            wready,
  output logic [ID_W-1:0] bid,
  output logic [1:0]      bresp,
  output logic            bvalid,
  input  logic            bready
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  logic stall_a, stall_w, stall_v;

`ifdef AXI_SLAVE_STALL_EN
  logic [15:0] lfsr;
  // Free-running Fibonacci LFSR (taps 16,14,13,11) whose low bits gate the channels
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall_a = lfsr[0];
  assign stall_w = lfsr[1];
  assign stall_v = lfsr[2];
`else
  assign stall_a = 1'b0;
  assign stall_w = 1'b0;
  assign stall_v = 1'b0;
`endif

  // ---------------- read channel ----------------
  r_state_t        r_state, r_next;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [3:0]      r_len, r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_oor, r_err, rv_q;
  logic [31:0]     mem_q;

  logic        ar_hs, r_hs, r_last_beat, rd_en, rd_in;
  logic [31:0] rd_a, rd_off;
  logic [2:0]  rd_size;
  logic [1:0]  rd_burst;

  assign ar_hs       = arvalid && arready;
  assign r_hs        = rvalid && rready;
  assign r_last_beat = (r_cnt == r_len);
  // The RAM is read on AR acceptance and on each non-final beat handshake, so the
  // next beat is always staged one cycle ahead of rvalid
  assign rd_en    = ar_hs || (r_hs && !r_last_beat);
  assign rd_a     = ar_hs ? araddr  : axi_next_addr(r_addr, r_size, r_burst);
  assign rd_size  = ar_hs ? arsize  : r_size;
  assign rd_burst = ar_hs ? arburst : r_burst;
  assign rd_off   = rd_a - BASE_ADDR;
  assign rd_in    = {1'b0, rd_off} < SPAN;

  // Read FSM next state and handshake outputs
  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = !stall_a;
        if (arvalid && arready) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = rv_q || !stall_v;
        if (rvalid && rready && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Read burst context, beat counter and per-beat error flags for the staged beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_oor   <= 1'b0;
      r_err   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      r_state <= r_next;
      rv_q    <= rvalid && !rready;
      if (ar_hs) begin
        r_id    <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
      end else if (r_hs && !r_last_beat) begin
        r_addr <= axi_next_addr(r_addr, r_size, r_burst);
        r_cnt  <= r_cnt + 4'd1;
      end
      if (rd_en) begin
        r_oor <= !rd_in;
        r_err <= !rd_in || (rd_size > 3'd2) || (rd_burst >= AXI_BURST_WRAP);
      end
    end
  end

  assign rid   = r_id;
  assign rlast = (r_state == R_DATA) && r_last_beat;
  assign rresp = ((r_state == R_DATA) && r_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign rdata = ((r_state == R_DATA) && !r_oor) ? mem_q : 32'd0;

  // ---------------- write channel ----------------
  w_state_t        w_state, w_next;
  logic [ID_W-1:0] w_id;
  logic [31:0]     w_addr, w_off;
  logic [3:0]      w_len, w_cnt;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic            w_err, bv_q;
  logic            aw_hs, w_hs, w_last_beat, w_in, w_bad;

  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_off       = w_addr - BASE_ADDR;
  assign w_in        = {1'b0, w_off} < SPAN;
  assign w_bad       = !w_in || (w_size > 3'd2) || (w_burst >= AXI_BURST_WRAP);

  // Write FSM next state and handshake outputs
  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = !stall_a;
        if (awvalid && awready) w_next = W_DATA;
      end
      W_DATA: begin
        wready = !stall_w;
        if (wvalid && wready && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = bv_q || !stall_v;
        if (bvalid && bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Write burst context; the burst ends on count==len and a disagreeing wlast only flags an error
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      w_state <= w_next;
      bv_q    <= bvalid && !bready;
      if (aw_hs) begin
        w_id    <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end else if (w_hs) begin
        w_err <= w_err || w_bad || (wlast != w_last_beat);
        if (!w_last_beat) begin
          w_addr <= axi_next_addr(w_addr, w_size, w_burst);
          w_cnt  <= w_cnt + 4'd1;
        end
      end
    end
  end

  assign bid   = w_id;
  assign bresp = ((w_state == W_RESP) && w_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

  axi_sram_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (rd_off[AW+1:2]),
    .rd_data (mem_q),
    .wr_en   (w_hs && w_in),
    .wr_addr (w_off[AW+1:2]),
    .wr_strb (wstrb),
    .wr_data (wdata)
  );

  logic unused_ok;
  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid,
                       rd_off[1:0], rd_off[31:AW+2], w_off[1:0], w_off[31:AW+2]};

endmodule
